// File: rtl/logic_axi4_stream_downsizer.sv
// rtl/logic_axi4_stream_downsizer.sv - splits each wide AXI4-Stream beat into narrow slices, LSB slice first
// Optional macro LOGIC_AXI4_STREAM_DOWNSIZER_NULL_SKIP_EN: slices with all-zero tkeep are not emitted.
module logic_axi4_stream_downsizer #(
    parameter int TDATA_BYTES    = 1,
    parameter int TUSER_WIDTH    = 1,
    parameter int RX_TDATA_BYTES = TDATA_BYTES,
    parameter int TX_TDATA_BYTES = TDATA_BYTES,
    parameter int RX_TUSER_WIDTH = TUSER_WIDTH,
    parameter int TX_TUSER_WIDTH = TUSER_WIDTH,
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int USE_TLAST      = 1,
    parameter int USE_TKEEP      = 1,
    parameter int USE_TSTRB      = 1
) (
    input  logic                        aclk,
    input  logic                        areset_n,
    input  logic [RX_TDATA_BYTES*8-1:0] rx_tdata_i,
    input  logic [RX_TDATA_BYTES-1:0]   rx_tkeep_i,
    input  logic [RX_TDATA_BYTES-1:0]   rx_tstrb_i,
    input  logic [RX_TUSER_WIDTH-1:0]   rx_tuser_i,
    input  logic [TDEST_WIDTH-1:0]      rx_tdest_i,
    input  logic [TID_WIDTH-1:0]        rx_tid_i,
    input  logic                        rx_tlast_i,
    input  logic                        rx_tvalid_i,
    output logic                        rx_tready_o,
    output logic [TX_TDATA_BYTES*8-1:0] tx_tdata_o,
    output logic [TX_TDATA_BYTES-1:0]   tx_tkeep_o,
    output logic [TX_TDATA_BYTES-1:0]   tx_tstrb_o,
    output logic [TX_TUSER_WIDTH-1:0]   tx_tuser_o,
    output logic [TDEST_WIDTH-1:0]      tx_tdest_o,
    output logic [TID_WIDTH-1:0]        tx_tid_o,
    output logic                        tx_tlast_o,
    output logic                        tx_tvalid_o,
    input  logic                        tx_tready_i
);
    localparam int RATIO = (TX_TDATA_BYTES > 0) ? RX_TDATA_BYTES / TX_TDATA_BYTES : 1;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int TXB   = TX_TDATA_BYTES;
    localparam int TXD   = TX_TDATA_BYTES * 8;
    localparam int TXU   = TX_TUSER_WIDTH;
`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_NULL_SKIP_EN
    localparam bit SKIP = (USE_TKEEP != 0);
`else
    localparam bit SKIP = 1'b0;
`endif

    generate
        if (TDATA_BYTES < 1 || TUSER_WIDTH < 1 || TX_TDATA_BYTES < 1 || TX_TUSER_WIDTH < 1 ||
            RATIO < 1 || RX_TDATA_BYTES != RATIO * TX_TDATA_BYTES ||
            RX_TUSER_WIDTH != RATIO * TX_TUSER_WIDTH) begin : g_param_check
            $error("logic_axi4_stream_downsizer: RX widths must be an integer multiple of TX widths");
        end
    endgenerate

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [RX_TDATA_BYTES*8-1:0] data_q;
    logic [RX_TDATA_BYTES-1:0]   keep_q;
    logic [RX_TDATA_BYTES-1:0]   strb_q;
    logic [RX_TUSER_WIDTH-1:0]   user_q;
    logic                        last_q;
    logic [TXD-1:0]              tx_tdata_q;
    logic [TXB-1:0]              tx_tkeep_q;
    logic [TXB-1:0]              tx_tstrb_q;
    logic [TXU-1:0]              tx_tuser_q;
    logic [TDEST_WIDTH-1:0]      tx_tdest_q;
    logic [TID_WIDTH-1:0]        tx_tid_q;
    logic                        tx_tlast_q;

    logic [RATIO-1:0] rx_nz, h_nz;
    logic [IDX_W-1:0] rx_first, rx_final, idx_d, h_final;
    logic             found_r, found_h;
    logic             is_final, rx_fire, tx_fire;

    always_comb begin
        rx_nz = '0;
        h_nz  = '0;
        for (int i = 0; i < RATIO; i++) begin
            rx_nz[i] = |rx_tkeep_i[i*TXB +: TXB];
            h_nz[i]  = |keep_q[i*TXB +: TXB];
        end
    end

    // Priority encoders locate the first/final emitted slice; an all-zero beat degenerates to slice 0 alone.
    always_comb begin
        rx_first = '0;
        rx_final = '0;
        h_final  = '0;
        idx_d    = idx_q;
        found_r  = 1'b0;
        found_h  = 1'b0;
        for (int i = 0; i < RATIO; i++) begin
            if (rx_nz[i]) begin
                if (!found_r) begin
                    rx_first = IDX_W'(i);
                    found_r  = 1'b1;
                end
                rx_final = IDX_W'(i);
            end
            if (h_nz[i]) begin
                h_final = IDX_W'(i);
                if (!found_h && i > int'(idx_q)) begin
                    idx_d   = IDX_W'(i);
                    found_h = 1'b1;
                end
            end
        end
        if (!SKIP) begin
            rx_first = '0;
            rx_final = IDX_W'(RATIO - 1);
            h_final  = IDX_W'(RATIO - 1);
            idx_d    = idx_q + IDX_W'(1);
        end
    end

    assign is_final    = (idx_q == h_final);
    assign tx_fire     = (state_q == BUSY) && tx_tready_i;
    assign rx_tready_o = (state_q == EMPTY) || (tx_fire && is_final);
    assign rx_fire     = rx_tvalid_i && rx_tready_o;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= EMPTY;
            idx_q      <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            strb_q     <= '0;
            user_q     <= '0;
            last_q     <= 1'b0;
            tx_tdata_q <= '0;
            tx_tkeep_q <= '0;
            tx_tstrb_q <= '0;
            tx_tuser_q <= '0;
            tx_tdest_q <= '0;
            tx_tid_q   <= '0;
            tx_tlast_q <= 1'b0;
        end else if (rx_fire) begin
            state_q    <= BUSY;
            idx_q      <= rx_first;
            data_q     <= rx_tdata_i;
            keep_q     <= rx_tkeep_i;
            strb_q     <= rx_tstrb_i;
            user_q     <= rx_tuser_i;
            last_q     <= rx_tlast_i;
            tx_tdata_q <= rx_tdata_i[int'(rx_first)*TXD +: TXD];
            tx_tkeep_q <= rx_tkeep_i[int'(rx_first)*TXB +: TXB];
            tx_tstrb_q <= rx_tstrb_i[int'(rx_first)*TXB +: TXB];
            tx_tuser_q <= rx_tuser_i[int'(rx_first)*TXU +: TXU];
            tx_tdest_q <= rx_tdest_i;
            tx_tid_q   <= rx_tid_i;
            tx_tlast_q <= rx_tlast_i && (rx_first == rx_final);
        end else if (tx_fire) begin
            if (is_final) begin
                state_q <= EMPTY;
            end else begin
                idx_q      <= idx_d;
                tx_tdata_q <= data_q[int'(idx_d)*TXD +: TXD];
                tx_tkeep_q <= keep_q[int'(idx_d)*TXB +: TXB];
                tx_tstrb_q <= strb_q[int'(idx_d)*TXB +: TXB];
                tx_tuser_q <= user_q[int'(idx_d)*TXU +: TXU];
                tx_tlast_q <= last_q && (idx_d == h_final);
            end
        end
    end

    assign tx_tvalid_o = (state_q == BUSY);
    assign tx_tdata_o  = tx_tdata_q;
    assign tx_tkeep_o  = (USE_TKEEP != 0) ? tx_tkeep_q : {TXB{1'b1}};
    assign tx_tstrb_o  = (USE_TSTRB != 0) ? tx_tstrb_q : tx_tkeep_o;
    assign tx_tuser_o  = tx_tuser_q;
    assign tx_tdest_o  = tx_tdest_q;
    assign tx_tid_o    = tx_tid_q;
    assign tx_tlast_o  = (USE_TLAST != 0) ? tx_tlast_q : 1'b0;

endmodule

// File: doc/logic_axi4_stream_downsizer.md
# logic_axi4_stream_downsizer

Splits each wide AXI4-Stream beat into an integer number of narrow beats, least-significant slice first. It is the counterpart stage to logic_axi4_stream_upsizer and sits directly downstream of it, returning upsized streams to a narrow datapath. Sideband signals (tuser, tkeep, tstrb) are sliced with tdata. tdest and tid are replicated on every slice, and tlast is moved to the final emitted slice.

## Interface
- TDATA_BYTES, 1, default byte count for both sides
- TUSER_WIDTH, 1, default tuser width for both sides
- RX_TDATA_BYTES, TDATA_BYTES, input beat bytes; must equal RATIO*TX_TDATA_BYTES, where RATIO is an integer ≥ 1
- TX_TDATA_BYTES, TDATA_BYTES, output beat bytes
- RX_TUSER_WIDTH, TUSER_WIDTH, input tuser bits; must equal RATIO*TX_TUSER_WIDTH
- TX_TUSER_WIDTH, TUSER_WIDTH, output tuser bits
- TDEST_WIDTH, 1, tdest bits
- TID_WIDTH, 1, tid bits
- USE_TLAST, 1, tlast enable; when 0, tx.tlast is driven 0
- USE_TKEEP, 1, tkeep enable; when 0, tx.tkeep is driven all-ones
- USE_TSTRB, 1, tstrb enable; when 0, tx.tstrb is driven equal to tx.tkeep
- aclk  input  1  clock; all logic is on the rising edge
- areset_n  input  1  asynchronous, active-low reset
- rx  slave modport  logic_axi4_stream_if  wide input stream
- tx  master modport  logic_axi4_stream_if  narrow output stream

## Operation
- Holding register: one wide beat with a valid flag, plus a slice index idx of width clog2(RATIO), minimum 1 bit.
- rx.tready = !held_valid || (tx.tvalid && tx.tready && current slice is the final emitted slice).
- An rx handshake loads the beat and sets idx to the first emitted slice.
- tx outputs are registered copies of slice idx:
  - tdata[idx*TX_TDATA_BYTES*8 +: TX_TDATA_BYTES*8]
  - tkeep and tstrb sliced the same way
  - tuser[idx*TX_TUSER_WIDTH +: TX_TUSER_WIDTH]
  - tdest and tid unchanged
- A tx handshake on a non-final slice advances idx to the next emitted slice.
- A tx handshake on the final slice either loads the next rx beat in the same cycle (if rx.tvalid) or clears held_valid.
- tx.tlast = held tlast AND (current slice is the final emitted slice).
- RATIO = 1: pure registered pass-through.
- Parameter violations are rejected at elaboration.
- States: EMPTY (held_valid = 0) and BUSY (held_valid = 1, idx = 0..RATIO-1).
  - EMPTY → BUSY on an rx handshake.
  - BUSY → BUSY on a final-slice handshake with a concurrent rx handshake.
  - BUSY → EMPTY on a final-slice handshake without one.

## Timing
- Reset values: tx.tvalid = 0; tx.tdata, tuser, tkeep, tstrb, tdest, tid and tlast = 0; idx = 0; held_valid = 0.
- rx.tready = 1 while reset is released and the block is empty.
- Latency: rx handshake in cycle t gives slice 0 on tx in cycle t+1.
- Throughput: one tx beat per cycle with no bubble between consecutive wide beats.
- AXI rule: while tx.tvalid && !tx.tready, all tx signals stay stable.
- rx.tready does not depend combinationally on rx.tvalid.
- Reset asserted mid-beat: the held beat is discarded and outputs return to reset values asynchronously. After release, the next rx beat starts from slice 0.

## Configuration
- Macro: LOGIC_AXI4_STREAM_DOWNSIZER_NULL_SKIP_EN.
- Defined with USE_TKEEP = 1:
  - Slices whose tkeep is all zero are not emitted; idx jumps to the next slice with a nonzero keep, found by priority encoder.
  - The final emitted slice is the highest slice with a nonzero keep.
  - If the whole beat has zero tkeep, slice 0 is emitted alone, carrying tlast.
- Undefined, or USE_TKEEP = 0: all RATIO slices are emitted regardless of tkeep.

## Test plan
All scenarios use RX_TDATA_BYTES = 4 and TX_TDATA_BYTES = 1 (RATIO = 4).
- Single beat, tx.tready = 1: rx tdata 0x44332211, tkeep 0xF, tlast 1 → tx beats 0x11, 0x22, 0x33, 0x44 in cycles t+1..t+4. tlast = 1 only on 0x44. rx.tready = 0 in cycles t+1..t+3.
- Back-to-back beats 0x44332211 then 0x88776655, tx.tready = 1 → 8 consecutive tx beats 0x11..0x88 with no idle cycle. Second beat is accepted on the cycle 0x44 is taken.
- Backpressure: tx.tready toggles 1,0,0,1,... → each slice's tdata, tkeep and tlast are held unchanged while tready = 0. No slice is lost or duplicated.
- Null skip: tkeep 0x5, tlast 1, tdata 0x44332211:
  - Macro defined → 2 beats, 0x11 then 0x33, tlast on 0x33.
  - Macro undefined → 4 beats with tkeep 1, 0, 1, 0 and tlast on the fourth.
- Sideband: RX_TUSER_WIDTH 8, TX_TUSER_WIDTH 2, tuser 0b11100100, tdest 3, tid 1 → tx tuser 0, 1, 2, 3 on the four slices. tdest 3 and tid 1 on every slice.
- Reset mid-beat: assert areset_n = 0 after slice 0x22 is accepted → tx.tvalid = 0 immediately. After release, a new beat 0xDDCCBBAA yields 0xAA first.
